writeback_arbiter: RTL
======================

# writeback_arbiter

Merges completed results from the ALU and the load/store unit onto the register file's single write port. It sits directly upstream of the register file and drives its write-enable, destination address and write data from registers. ALU results that lose arbitration wait in a small in-order FIFO. The block preserves program-order writes to the same destination and exports a pending-write mask for the hazard logic.

## Interface
- XLEN, 32, data width of results and of the register write port
- REG_ADDR_WIDTH, 5, architectural register index width (32 registers)
- ALU_FIFO_DEPTH, 2, ALU result buffer entries; a power of two, at least 2

- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU result available
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high
- alu_rd  input  REG_ADDR_WIDTH  ALU destination register
- alu_data  input  XLEN  ALU result
- lsu_valid  input  1  load result available
- lsu_ready  output  1  load result accepted this cycle when lsu_valid is also high
- lsu_rd  input  REG_ADDR_WIDTH  load destination register
- lsu_data  input  XLEN  load result
- wb_write_enable  output  1  register file write strobe
- wb_addr_rd  output  REG_ADDR_WIDTH  register file write address
- wb_data_rd  output  XLEN  register file write data
- pending_mask  output  2**REG_ADDR_WIDTH  bit i set while a FIFO entry targets register i
- fifo_count  output  $clog2(ALU_FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- A handshake completes in a cycle when valid and ready are both high.
- `alu_ready` = (fifo_count < ALU_FIFO_DEPTH). It depends on state only.
- `conflict` = lsu_valid, lsu_rd != 0, and lsu_rd matches the rd of any valid FIFO entry.
- `lsu_ready` = (fifo_count < ALU_FIFO_DEPTH) and not conflict. This path is combinational from the lsu inputs.
- Grant priority each cycle (exactly one source, or none):
  1. FIFO full: the FIFO head is granted.
  2. LSU handshake: the LSU is granted.
  3. fifo_count > 0: the FIFO head is granted. This also covers a conflict stall, so the older ALU write always precedes the load to the same rd.
  4. FIFO empty and ALU handshake: the ALU is granted directly, bypassing the FIFO.
- An accepted ALU result that is not directly granted is pushed at the FIFO tail.
- A FIFO pop and a push may happen in the same cycle. A push is never allowed while full, because alu_ready is low.
- On a grant, the next cycle shows wb_write_enable = (granted rd != 0), with wb_addr_rd and wb_data_rd taken from the granted source.
- With no grant, wb_write_enable = 0 and wb_addr_rd / wb_data_rd hold their values.
- Results for x0 complete their handshake and occupy a grant slot, but never assert wb_write_enable.
- pending_mask is the OR of one-hot(rd) over valid FIFO entries, excluding rd = 0. It is recomputed from the registered FIFO state.
- FIFO pointers wrap modulo ALU_FIFO_DEPTH. fifo_count ranges 0..ALU_FIFO_DEPTH.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release) clears:
  - FIFO pointers, fifo_count = 0, all entry valids
  - wb_write_enable = 0, wb_addr_rd = 0, wb_data_rd = 0, pending_mask = 0
- During and after reset, alu_ready = 1, and lsu_ready = 1 when there is no conflict.
- Reset mid-operation discards all buffered results. No write strobe follows the reset.
- Latency, handshake to wb_write_enable:
  - 1 cycle for an LSU grant or a direct ALU grant
  - ≥ 2 cycles for a buffered ALU result
- Throughput: one register write per cycle.
- Per-source order is preserved: ALU results retire in acceptance order.
- Loads retire in acceptance order and never overtake an older same-rd ALU result.
- ALU and LSU results with different rd may retire out of arrival order.

## Test plan
- Reset, then a single ALU result (rd=5, data 0xDEADBEEF) with the LSU idle:
  - direct grant
  - next cycle wb_write_enable=1, wb_addr_rd=5, wb_data_rd=0xDEADBEEF
  - fifo_count stays 0
- Same-cycle ALU (rd=3, 0x11) and LSU (rd=4, 0x22) results:
  - LSU written first, ALU buffered with pending_mask bit 3 set
  - ALU written on the following cycle
  - pending_mask returns to 0
- FIFO holds ALU rd=7, then a load to rd=7 arrives:
  - lsu_ready=0 until the rd=7 entry pops
  - write order is 7←ALU, then 7←load
- LSU valid every cycle for 4 cycles while the ALU issues 3 results (depth 2):
  - FIFO fills and alu_ready drops
  - on the full cycle the FIFO head wins and lsu_ready=0
  - every result is written exactly once
- ALU result with rd=0 and LSU result with rd=0:
  - both handshakes complete
  - wb_write_enable never asserts
  - pending_mask stays 0
- Assert reset_n=0 with 2 buffered entries:
  - fifo_count=0, pending_mask=0 and wb_write_enable=0 immediately
  - no writes after release

Source files
------------

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port.
// Losing ALU results wait in a small in-order FIFO; loads never pass an older ALU write to the same rd.
module writeback_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       alu_rd,
    input  logic [XLEN-1:0]                 alu_data,
    input  logic                            lsu_valid,
    output logic                            lsu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       lsu_rd,
    input  logic [XLEN-1:0]                 lsu_data,
    output logic                            wb_write_enable,
    output logic [REG_ADDR_WIDTH-1:0]       wb_addr_rd,
    output logic [XLEN-1:0]                 wb_data_rd,
    output logic [2**REG_ADDR_WIDTH-1:0]    pending_mask,
    output logic [$clog2(ALU_FIFO_DEPTH):0] fifo_count
);
    localparam int PTR_W = $clog2(ALU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 2**REG_ADDR_WIDTH;

    logic [REG_ADDR_WIDTH-1:0] entry_rd_reg   [ALU_FIFO_DEPTH];
    logic [XLEN-1:0]           entry_data_reg [ALU_FIFO_DEPTH];
    logic [ALU_FIFO_DEPTH-1:0] entry_valid_reg, entry_valid_next;
    logic [PTR_W-1:0]          rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]          count_reg, count_next;
    logic                      wb_we_reg;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_reg;
    logic [XLEN-1:0]           wb_data_reg;

    logic [ALU_FIFO_DEPTH-1:0] rd_match;
    logic [NREGS-1:0]          entry_onehot [ALU_FIFO_DEPTH];
    logic                      full, conflict, alu_hs, lsu_hs, push, pop;
    logic                      grant_fifo, grant_lsu, grant_alu;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [XLEN-1:0]           sel_data;
    logic [NREGS-1:0]          mask_comb;

    genvar gi;
    generate
        for (gi = 0; gi < ALU_FIFO_DEPTH; gi++) begin : g_entry
            assign rd_match[gi]     = entry_valid_reg[gi] && (entry_rd_reg[gi] == lsu_rd);
            // x0 is never a hazard, so it is left out of the mask.
            assign entry_onehot[gi] = (entry_valid_reg[gi] && (entry_rd_reg[gi] != '0))
                                      ? (NREGS'(1) << entry_rd_reg[gi]) : '0;
        end
    endgenerate

    assign full      = (count_reg == CNT_W'(ALU_FIFO_DEPTH));
    assign conflict  = lsu_valid && (lsu_rd != '0) && (|rd_match);
    assign alu_ready = !full;
    assign lsu_ready = !full && !conflict;
    assign alu_hs    = alu_valid && alu_ready;
    assign lsu_hs    = lsu_valid && lsu_ready;

    always_comb begin
        grant_fifo = 1'b0;
        grant_lsu  = 1'b0;
        grant_alu  = 1'b0;
        if (full)                    grant_fifo = 1'b1;
        else if (lsu_hs)             grant_lsu  = 1'b1;
        else if (count_reg != '0)    grant_fifo = 1'b1;
        else if (alu_hs)             grant_alu  = 1'b1;
    end

    assign push       = alu_hs && !grant_alu;
    assign pop        = grant_fifo;
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        entry_valid_next = entry_valid_reg;
        if (pop)  entry_valid_next[rd_ptr_reg] = 1'b0;
        if (push) entry_valid_next[wr_ptr_reg] = 1'b1;
    end

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (grant_fifo) begin
            sel_rd   = entry_rd_reg[rd_ptr_reg];
            sel_data = entry_data_reg[rd_ptr_reg];
        end else if (grant_lsu) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            entry_valid_reg <= '0;
            wb_we_reg       <= 1'b0;
            wb_addr_reg     <= '0;
            wb_data_reg     <= '0;
        end else begin
            count_reg       <= count_next;
            entry_valid_reg <= entry_valid_next;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            wb_we_reg <= 1'b0;
            if (grant_fifo || grant_lsu || grant_alu) begin
                wb_we_reg   <= (sel_rd != '0);
                wb_addr_reg <= sel_rd;
                wb_data_reg <= sel_data;
            end
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clock) begin
        if (push) begin
            entry_rd_reg[wr_ptr_reg]   <= alu_rd;
            entry_data_reg[wr_ptr_reg] <= alu_data;
        end
    end

    always_comb begin
        mask_comb = '0;
        for (int i = 0; i < ALU_FIFO_DEPTH; i++) mask_comb = mask_comb | entry_onehot[i];
    end

    assign pending_mask    = mask_comb;
    assign fifo_count      = count_reg;
    assign wb_write_enable = wb_we_reg;
    assign wb_addr_rd      = wb_addr_reg;
    assign wb_data_rd      = wb_data_reg;
endmodule
